dispatch_queue: RTL and testbench
=================================

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 8: write lanes per cycle.
REQ-002 SHALL have parameter DISPATCH_WIDTH, default 4: read lanes per cycle.
REQ-003 SHALL have parameter DEPTH, default 32: entries, power of 2, at least FETCH_WIDTH+DISPATCH_WIDTH.
REQ-004 SHALL have parameter PKT_W, default 128: decoded packet width in bits.
REQ-005 SHALL have parameter BR_BIT, default 127: index of the is-branch flag within a packet.
REQ-006 SHALL have parameter PARTIAL_DISPATCH, default 1: 1 = partial dispatch allowed; 0 = only full DISPATCH_WIDTH groups are offered.
REQ-007 SHALL have ports, in this order:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- flush_i, in, 1: misprediction flush.
- wrValid_i, in, 1: write group valid.
- wrVector_i, in, FETCH_WIDTH: per-lane valid; may be sparse.
- wrPacket_i, in, FETCH_WIDTH*PKT_W: lane k at bits [k*PKT_W +: PKT_W].
- stallFetch_o, out, 1: queue cannot accept a full fetch group.
- dispValid_o, out, DISPATCH_WIDTH: thermometer mask of offered slots.
- dispPacket_o, out, DISPATCH_WIDTH*PKT_W: head-ordered packets.
- consume_i, in, log2(DISPATCH_WIDTH)+1: number of offered slots taken this cycle.
- branchCount_o, out, log2(DISPATCH_WIDTH)+1: branches among the offered slots.
- count_o, out, log2(DEPTH)+1: current occupancy.

Function
REQ-008 The block SHALL hold headPtr and tailPtr of log2(DEPTH) bits each, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-009 stallFetch_o SHALL be combinational and SHALL equal (DEPTH - count) < FETCH_WIDTH.
REQ-010 A write SHALL occur only when wrValid_i=1 and stallFetch_o=0; otherwise the entire group is dropped.
REQ-011 On a write, valid lanes SHALL be compacted in ascending lane order into tail, tail+1, ... (mod DEPTH), and invalid lanes SHALL leave no gap.
REQ-012 On a write, tailPtr SHALL advance by popcount(wrVector_i).
REQ-013 Offered slots SHALL be n = min(count, DISPATCH_WIDTH) when PARTIAL_DISPATCH=1; when PARTIAL_DISPATCH=0, n = DISPATCH_WIDTH if count >= DISPATCH_WIDTH, else 0.
REQ-014 dispValid_o[j] SHALL be 1 exactly for j < n; dispPacket_o slot j SHALL be the entry at headPtr+j (mod DEPTH).
REQ-015 Data on slots with dispValid_o[j]=0 SHALL be don't-care.
REQ-016 Read latency SHALL be one cycle: an entry written at edge T is offerable from T+1; there is no write-to-read bypass.
REQ-017 branchCount_o SHALL count packet bit BR_BIT over valid slots only.
REQ-018 headPtr SHALL advance by consume_i.
REQ-019 A consume_i value greater than n is illegal; RTL SHALL clamp it to n, and the bench SHALL flag it with an assertion.
REQ-020 On each edge, count SHALL update as count + written - consumed, using the consumed value after clamping.
REQ-021 A simultaneous write and consume SHALL both take effect in the same cycle; the free-space check uses the pre-edge count.
REQ-022 count SHALL never exceed DEPTH; count = DEPTH SHALL be reachable only when FETCH_WIDTH divides the gaps exactly.
REQ-023 At count = 0, n SHALL be 0 and consume_i SHALL be ignored.
REQ-024 count_o SHALL equal the registered count.
REQ-025 flush_i=1 SHALL set headPtr, tailPtr and count to 0 on the next edge.
REQ-026 Flush SHALL take priority over a same-cycle write and consume; the write is dropped.
REQ-027 Storage contents need no reset; only the pointers and count are reset.

Reset
REQ-028 With reset_n=0 at a rising edge, headPtr, tailPtr and count SHALL become 0.
REQ-029 After that edge, dispValid_o SHALL be 0, branchCount_o 0, count_o 0 and stallFetch_o 0.
REQ-030 Reset SHALL override flush, write and consume.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries.
REQ-032 Outputs are undefined before the first reset edge.

Verification
REQ-033 Sparse compaction: wrVector_i=8'b1010_0101 into an empty queue -> next cycle count_o=4, dispValid_o=4'b1111, slots 0..3 carry lanes 0,2,5,7.
REQ-034 Partial versus full mode: count=3, consume_i=0 -> PARTIAL_DISPATCH=1 gives dispValid_o=4'b0111; PARTIAL_DISPATCH=0 gives 4'b0000.
REQ-035 Full boundary: count=25, DEPTH=32 -> stallFetch_o=1 and a write is dropped; with count=24 the write is accepted, and an 8-lane write then gives count=32.
REQ-036 Wrap-around: tailPtr=30, 4-lane write -> entries land at 30, 31, 0, 1; later reads from headPtr=30 return them in order.
REQ-037 Simultaneous flush, write and consume=2 at count=10 -> next cycle count_o=0 and dispValid_o=0.
REQ-038 Reset mid-stream: reset_n=0 for one edge with count=17 -> count_o=0 and stallFetch_o=0; the first write afterwards appears at slot 0.

Source files
------------

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if
//   Bundles the fetch-side write group, the dispatch-side offer/consume
//   handshake and the occupancy status of a dispatch_queue instance.
//   Ports (signal | driven by | meaning):
//     flush_i       | master | misprediction flush
//     wrValid_i     | master | write group valid
//     wrVector_i    | master | per-lane valid, may be sparse
//     wrPacket_i    | master | lane k at [k*PKT_W +: PKT_W]
//     consume_i     | master | number of offered slots taken
//     stallFetch_o  | slave  | queue cannot take a full fetch group
//     dispValid_o   | slave  | thermometer mask of offered slots
//     dispPacket_o  | slave  | head-ordered offered packets
//     branchCount_o | slave  | branches among the offered slots
//     count_o       | slave  | current occupancy
interface dispatch_queue_if #(
   parameter int FETCH_WIDTH    = 8,
   parameter int DISPATCH_WIDTH = 4,
   parameter int DEPTH          = 32,
   parameter int PKT_W          = 128
);
   localparam int CW   = $clog2(DISPATCH_WIDTH) + 1;
   localparam int CNTW = $clog2(DEPTH) + 1;

   logic                              flush_i;
   logic                              wrValid_i;
   logic [FETCH_WIDTH-1:0]            wrVector_i;
   logic [FETCH_WIDTH*PKT_W-1:0]      wrPacket_i;
   logic                              stallFetch_o;
   logic [DISPATCH_WIDTH-1:0]         dispValid_o;
   logic [DISPATCH_WIDTH*PKT_W-1:0]   dispPacket_o;
   logic [CW-1:0]                     consume_i;
   logic [CW-1:0]                     branchCount_o;
   logic [CNTW-1:0]                   count_o;

   modport master (
      output flush_i, wrValid_i, wrVector_i, wrPacket_i, consume_i,
      input  stallFetch_o, dispValid_o, dispPacket_o, branchCount_o, count_o
   );

   modport slave (
      input  flush_i, wrValid_i, wrVector_i, wrPacket_i, consume_i,
      output stallFetch_o, dispValid_o, dispPacket_o, branchCount_o, count_o
   );
endinterface

// File: rtl/dispatch_queue.sv
// dispatch_queue
//   Circular buffer between a wide fetch/decode stage and a narrower
//   dispatch stage. Each cycle a sparse fetch group is compacted into the
//   tail, and up to DISPATCH_WIDTH head entries are offered for dispatch.
//   Ports:
//     clk      | rising-edge clock for all state
//     reset_n  | synchronous active-low reset of pointers and count
//     dq       | dispatch_queue_if slave (write group, offer/consume, status)
module dispatch_queue #(
   parameter int FETCH_WIDTH      = 8,
   parameter int DISPATCH_WIDTH   = 4,
   parameter int DEPTH            = 32,
   parameter int PKT_W            = 128,
   parameter int BR_BIT           = 127,
   parameter int PARTIAL_DISPATCH = 1
) (
   input logic             clk,
   input logic             reset_n,
   dispatch_queue_if.slave dq
);
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = $clog2(DISPATCH_WIDTH) + 1;

   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
   localparam logic [CNTW-1:0] FW_C    = CNTW'(FETCH_WIDTH);
   localparam logic [CNTW-1:0] DW_C    = CNTW'(DISPATCH_WIDTH);
   localparam logic [CW-1:0]   DW_N    = CW'(DISPATCH_WIDTH);

   logic [PKT_W-1:0]                mem_q [DEPTH];
   logic [PW-1:0]                   head_q, head_d;
   logic [PW-1:0]                   tail_q, tail_d;
   logic [CNTW-1:0]                 count_q, count_d;

   logic [CNTW-1:0]                 free_slots;
   logic                            stall;
   logic                            wr_en;
   logic                            mem_we;
   logic [CNTW-1:0]                 wr_cnt;
   logic [PW-1:0]                   lane_addr [FETCH_WIDTH];

   logic [CW-1:0]                   offer_n;
   logic [CW-1:0]                   take_n;
   logic [DISPATCH_WIDTH-1:0]       disp_valid;
   logic [DISPATCH_WIDTH*PKT_W-1:0] disp_pkt;
   logic [CW-1:0]                   br_cnt;

   // Free-space check always uses the pre-edge count, so a same-cycle
   // consume never makes room for the write in that cycle.
   assign free_slots = DEPTH_C - count_q;
   assign stall      = free_slots < FW_C;
   assign wr_en      = dq.wrValid_i & ~stall;
   assign mem_we     = wr_en & ~dq.flush_i & reset_n;

   // Compaction: each valid lane lands at tail plus the number of valid
   // lanes below it, so invalid lanes leave no hole.
   always_comb begin
      wr_cnt = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         lane_addr[k] = tail_q + wr_cnt[PW-1:0];
         if (dq.wrVector_i[k]) begin
            wr_cnt = wr_cnt + CNTW'(1);
         end
      end
   end

   // In full-group mode nothing is offered until a whole group is present.
   always_comb begin
      offer_n = '0;
      if (count_q >= DW_C) begin
         offer_n = DW_N;
      end else if (PARTIAL_DISPATCH != 0) begin
         offer_n = count_q[CW-1:0];
      end
   end

   // Over-consumption is clamped to what was actually offered.
   assign take_n = (dq.consume_i > offer_n) ? offer_n : dq.consume_i;

   always_comb begin
      disp_valid = '0;
      disp_pkt   = '0;
      br_cnt     = '0;
      for (int j = 0; j < DISPATCH_WIDTH; j++) begin
         disp_valid[j]              = CW'(j) < offer_n;
         disp_pkt[j*PKT_W +: PKT_W] = mem_q[head_q + PW'(j)];
         if (disp_valid[j] && disp_pkt[j*PKT_W + BR_BIT]) begin
            br_cnt = br_cnt + CW'(1);
         end
      end
   end

   // Flush wins over any same-cycle write and consume.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (dq.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(take_n);
         if (wr_en) begin
            tail_d = tail_q + wr_cnt[PW-1:0];
         end
         count_d = count_q + (wr_en ? wr_cnt : '0) - CNTW'(take_n);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; only entries below count are ever offered.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (dq.wrVector_i[k]) begin
               mem_q[lane_addr[k]] <= dq.wrPacket_i[k*PKT_W +: PKT_W];
            end
         end
      end
   end

   assign dq.stallFetch_o  = stall;
   assign dq.dispValid_o   = disp_valid;
   assign dq.dispPacket_o  = disp_pkt;
   assign dq.branchCount_o = br_cnt;
   assign dq.count_o       = count_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue
//   Drives two queues (partial and full-group dispatch) with the same write
//   stream. Written packets are pushed to a scoreboard queue and popped and
//   compared against the offered slots when they are consumed.
module tb_dispatch_queue;
   localparam int FW    = 8;
   localparam int DW    = 4;
   localparam int DEPTH = 32;
   localparam int PKT_W = 128;
   localparam int BR    = 127;

   typedef logic [PKT_W-1:0] pkt_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   dispatch_queue_if #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PKT_W)) q1 ();
   dispatch_queue_if #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PKT_W)) q0 ();

   dispatch_queue #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PKT_W),
                    .BR_BIT(BR), .PARTIAL_DISPATCH(1)) dut (
      .clk(clk), .reset_n(reset_n), .dq(q1));

   dispatch_queue #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PKT_W),
                    .BR_BIT(BR), .PARTIAL_DISPATCH(0)) dut_full (
      .clk(clk), .reset_n(reset_n), .dq(q0));

   pkt_t sb[$];
   int   cnt0;
   int   errors = 0;
   int   checks = 0;
   bit   allow_illegal = 1'b0;
   int   exp_n_drv = 0;
   int   cons_drv  = 0;
   pkt_t lanes [FW];

   always @(negedge clk) begin
      if (reset_n === 1'b1 && !allow_illegal) begin
         assert (cons_drv <= exp_n_drv)
            else $error("illegal consume %0d with %0d offered", cons_drv, exp_n_drv);
      end
   end

   function automatic int popc8(input logic [7:0] v);
      int c = 0;
      for (int i = 0; i < 8; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic int n_part(input int c);
      return (c >= DW) ? DW : c;
   endfunction

   function automatic int br_exp();
      int b = 0;
      for (int j = 0; j < n_part(sb.size()); j++) b += int'(sb[j][BR]);
      return b;
   endfunction

   function automatic logic [DW-1:0] mask_of(input int n);
      return DW'((1 << n) - 1);
   endfunction

   // One clock: present inputs, check consumed slots against the
   // scoreboard, update the models, then advance past the edge.
   task automatic drive(input bit fl, input bit wv, input logic [7:0] vec, input int cons);
      int n1, take, n0, take0, wcnt;
      bit acc1, acc0;
      logic [FW*PKT_W-1:0] bus;
      for (int k = 0; k < FW; k++) begin
         lanes[k] = {$urandom, $urandom, $urandom, $urandom};
         bus[k*PKT_W +: PKT_W] = lanes[k];
      end
      n1    = n_part(sb.size());
      take  = (cons < n1) ? cons : n1;
      n0    = (cnt0 >= DW) ? DW : 0;
      take0 = (cons < n0) ? cons : n0;
      wcnt  = popc8(vec);
      acc1  = wv && !fl && ((DEPTH - sb.size()) >= FW);
      acc0  = wv && !fl && ((DEPTH - cnt0) >= FW);
      q1.flush_i = fl;   q0.flush_i = fl;
      q1.wrValid_i = wv; q0.wrValid_i = wv;
      q1.wrVector_i = vec; q0.wrVector_i = vec;
      q1.wrPacket_i = bus; q0.wrPacket_i = bus;
      q1.consume_i = 3'(cons);
      q0.consume_i = 3'(take0);
      exp_n_drv = n1;
      cons_drv  = cons;
      for (int j = 0; j < take; j++) begin
         checks++;
         if (q1.dispPacket_o[j*PKT_W +: PKT_W] !== sb[j]) begin
            errors++;
            $display("FAIL sb_slot%0d: got %h expected %h", j, q1.dispPacket_o[j*PKT_W +: PKT_W], sb[j]);
         end
      end
      if (fl) begin
         sb.delete();
         cnt0 = 0;
      end else begin
         repeat (take) void'(sb.pop_front());
         if (acc1) for (int k = 0; k < FW; k++) if (vec[k]) sb.push_back(lanes[k]);
         cnt0 = cnt0 + (acc0 ? wcnt : 0) - take0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q1.flush_i = 1'b1; q0.flush_i = 1'b1;
      q1.wrValid_i = 1'b1; q0.wrValid_i = 1'b1;
      q1.wrVector_i = 8'hFF; q0.wrVector_i = 8'hFF;
      q1.wrPacket_i = '1; q0.wrPacket_i = '1;
      q1.consume_i = 3'd2; q0.consume_i = 3'd2;
      cons_drv = 0; exp_n_drv = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      q1.flush_i = 1'b0; q0.flush_i = 1'b0;
      q1.wrValid_i = 1'b0; q0.wrValid_i = 1'b0;
      q1.consume_i = '0; q0.consume_i = '0;
      sb.delete();
      cnt0 = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", q1.count_o); end
      checks++; if (q1.dispValid_o !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0000", q1.dispValid_o); end
      checks++; if (q1.branchCount_o !== 3'd0) begin errors++; $display("FAIL reset_brcnt: got %0d expected 0", q1.branchCount_o); end
      checks++; if (q1.stallFetch_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", q1.stallFetch_o); end
      checks++; if (q0.count_o !== 6'd0) begin errors++; $display("FAIL reset_count_full: got %0d expected 0", q0.count_o); end
   endtask

   task automatic test_sparse();
      pkt_t l0, l2, l5, l7;
      int br;
      checks++; if (q1.dispValid_o !== 4'b0) begin errors++; $display("FAIL sparse_pre_valid: got %b expected 0000", q1.dispValid_o); end
      drive(1'b0, 1'b1, 8'b1010_0101, 0);
      l0 = lanes[0]; l2 = lanes[2]; l5 = lanes[5]; l7 = lanes[7];
      br = int'(l0[BR]) + int'(l2[BR]) + int'(l5[BR]) + int'(l7[BR]);
      checks++; if (q1.count_o !== 6'd4) begin errors++; $display("FAIL sparse_count: got %0d expected 4", q1.count_o); end
      checks++; if (q1.dispValid_o !== 4'b1111) begin errors++; $display("FAIL sparse_valid: got %b expected 1111", q1.dispValid_o); end
      checks++; if (q1.dispPacket_o[0*PKT_W +: PKT_W] !== l0) begin errors++; $display("FAIL sparse_slot0: got %h expected %h", q1.dispPacket_o[0*PKT_W +: PKT_W], l0); end
      checks++; if (q1.dispPacket_o[1*PKT_W +: PKT_W] !== l2) begin errors++; $display("FAIL sparse_slot1: got %h expected %h", q1.dispPacket_o[1*PKT_W +: PKT_W], l2); end
      checks++; if (q1.dispPacket_o[2*PKT_W +: PKT_W] !== l5) begin errors++; $display("FAIL sparse_slot2: got %h expected %h", q1.dispPacket_o[2*PKT_W +: PKT_W], l5); end
      checks++; if (q1.dispPacket_o[3*PKT_W +: PKT_W] !== l7) begin errors++; $display("FAIL sparse_slot3: got %h expected %h", q1.dispPacket_o[3*PKT_W +: PKT_W], l7); end
      checks++; if (int'(q1.branchCount_o) !== br) begin errors++; $display("FAIL sparse_brcnt: got %0d expected %0d", q1.branchCount_o, br); end
      drive(1'b0, 1'b0, 8'h00, 4);
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL sparse_drain: got %0d expected 0", q1.count_o); end
   endtask

   task automatic test_partial();
      drive(1'b1, 1'b0, 8'h00, 0);
      drive(1'b0, 1'b1, 8'h07, 0);
      checks++; if (q1.dispValid_o !== 4'b0111) begin errors++; $display("FAIL partial_valid: got %b expected 0111", q1.dispValid_o); end
      checks++; if (q0.dispValid_o !== 4'b0000) begin errors++; $display("FAIL full_mode_valid: got %b expected 0000", q0.dispValid_o); end
      checks++; if (q0.count_o !== 6'd3) begin errors++; $display("FAIL full_mode_count: got %0d expected 3", q0.count_o); end
      checks++; if (int'(q1.branchCount_o) !== br_exp()) begin errors++; $display("FAIL partial_brcnt: got %0d expected %0d", q1.branchCount_o, br_exp()); end
      checks++; if (q0.branchCount_o !== 3'd0) begin errors++; $display("FAIL full_mode_brcnt: got %0d expected 0", q0.branchCount_o); end
      drive(1'b0, 1'b0, 8'h00, 3);
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL partial_drain: got %0d expected 0", q1.count_o); end
      checks++; if (int'(q0.count_o) !== cnt0) begin errors++; $display("FAIL full_mode_hold: got %0d expected %0d", q0.count_o, cnt0); end
   endtask

   task automatic test_full_boundary();
      drive(1'b1, 1'b0, 8'h00, 0);
      repeat (3) drive(1'b0, 1'b1, 8'hFF, 0);
      drive(1'b0, 1'b1, 8'h01, 0);
      checks++; if (q1.stallFetch_o !== 1'b1) begin errors++; $display("FAIL stall_at25: got %b expected 1", q1.stallFetch_o); end
      drive(1'b0, 1'b1, 8'hFF, 0);
      checks++; if (q1.count_o !== 6'd25) begin errors++; $display("FAIL drop_at25: got %0d expected 25", q1.count_o); end
      drive(1'b0, 1'b0, 8'h00, 1);
      checks++; if (q1.stallFetch_o !== 1'b0) begin errors++; $display("FAIL stall_at24: got %b expected 0", q1.stallFetch_o); end
      drive(1'b0, 1'b1, 8'hFF, 0);
      checks++; if (q1.count_o !== 6'd32) begin errors++; $display("FAIL count_full: got %0d expected 32", q1.count_o); end
      checks++; if (q1.stallFetch_o !== 1'b1) begin errors++; $display("FAIL stall_full: got %b expected 1", q1.stallFetch_o); end
      checks++; if (q0.count_o !== 6'd32) begin errors++; $display("FAIL count_full_fm: got %0d expected 32", q0.count_o); end
      repeat (8) drive(1'b0, 1'b0, 8'h00, 4);
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", q1.count_o); end
   endtask

   task automatic test_wrap();
      pkt_t w [4];
      drive(1'b1, 1'b0, 8'h00, 0);
      repeat (3) drive(1'b0, 1'b1, 8'hFF, 0);
      drive(1'b0, 1'b1, 8'h3F, 0);
      repeat (7) drive(1'b0, 1'b0, 8'h00, 4);
      drive(1'b0, 1'b0, 8'h00, 2);
      drive(1'b0, 1'b1, 8'h0F, 0);
      for (int i = 0; i < 4; i++) w[i] = lanes[i];
      checks++; if (q1.dispValid_o !== 4'b1111) begin errors++; $display("FAIL wrap_valid: got %b expected 1111", q1.dispValid_o); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q1.dispPacket_o[i*PKT_W +: PKT_W] !== w[i]) begin
            errors++; $display("FAIL wrap_slot%0d: got %h expected %h", i, q1.dispPacket_o[i*PKT_W +: PKT_W], w[i]);
         end
      end
      drive(1'b0, 1'b0, 8'h00, 4);
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL wrap_drain: got %0d expected 0", q1.count_o); end
   endtask

   task automatic test_flush();
      drive(1'b1, 1'b0, 8'h00, 0);
      drive(1'b0, 1'b1, 8'hFF, 0);
      drive(1'b0, 1'b1, 8'h03, 0);
      checks++; if (q1.count_o !== 6'd10) begin errors++; $display("FAIL flush_pre: got %0d expected 10", q1.count_o); end
      drive(1'b1, 1'b1, 8'hFF, 2);
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", q1.count_o); end
      checks++; if (q1.dispValid_o !== 4'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0000", q1.dispValid_o); end
      checks++; if (q0.count_o !== 6'd0) begin errors++; $display("FAIL flush_count_fm: got %0d expected 0", q0.count_o); end
   endtask

   task automatic test_clamp();
      drive(1'b0, 1'b1, 8'h03, 0);
      allow_illegal = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 4);
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL clamp_count: got %0d expected 0", q1.count_o); end
      checks++; if (int'(q0.count_o) !== cnt0) begin errors++; $display("FAIL clamp_count_fm: got %0d expected %0d", q0.count_o, cnt0); end
      drive(1'b0, 1'b0, 8'h00, 3);
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL empty_consume: got %0d expected 0", q1.count_o); end
      checks++; if (q1.dispValid_o !== 4'b0) begin errors++; $display("FAIL empty_valid: got %b expected 0000", q1.dispValid_o); end
      allow_illegal = 1'b0;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 8'h00, 0);
      for (int c = 0; c < 300; c++) begin
         bit fl, wv;
         int cons;
         fl   = ($urandom_range(0, 49) == 0);
         wv   = ($urandom_range(0, 3) != 0);
         cons = $urandom_range(0, n_part(sb.size()));
         drive(fl, wv, 8'($urandom), cons);
         checks++; if (int'(q1.count_o) !== sb.size()) begin errors++; $display("FAIL b2b_count c%0d: got %0d expected %0d", c, q1.count_o, sb.size()); end
         checks++; if (q1.dispValid_o !== mask_of(n_part(sb.size()))) begin errors++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, q1.dispValid_o, mask_of(n_part(sb.size()))); end
         checks++; if (q1.stallFetch_o !== ((DEPTH - sb.size()) < FW)) begin errors++; $display("FAIL b2b_stall c%0d: got %b", c, q1.stallFetch_o); end
         checks++; if (int'(q1.branchCount_o) !== br_exp()) begin errors++; $display("FAIL b2b_brcnt c%0d: got %0d expected %0d", c, q1.branchCount_o, br_exp()); end
         checks++; if (int'(q0.count_o) !== cnt0) begin errors++; $display("FAIL b2b_count_fm c%0d: got %0d expected %0d", c, q0.count_o, cnt0); end
      end
   endtask

   task automatic test_reset_midstream();
      pkt_t first;
      drive(1'b1, 1'b0, 8'h00, 0);
      drive(1'b0, 1'b1, 8'hFF, 0);
      drive(1'b0, 1'b1, 8'hFF, 0);
      drive(1'b0, 1'b1, 8'h01, 0);
      checks++; if (q1.count_o !== 6'd17) begin errors++; $display("FAIL mid_pre: got %0d expected 17", q1.count_o); end
      do_reset();
      checks++; if (q1.count_o !== 6'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", q1.count_o); end
      checks++; if (q1.stallFetch_o !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b expected 0", q1.stallFetch_o); end
      drive(1'b0, 1'b1, 8'h04, 0);
      first = lanes[2];
      checks++; if (q1.dispPacket_o[0 +: PKT_W] !== first) begin errors++; $display("FAIL mid_slot0: got %h expected %h", q1.dispPacket_o[0 +: PKT_W], first); end
      checks++; if (q1.dispValid_o !== 4'b0001) begin errors++; $display("FAIL mid_valid: got %b expected 0001", q1.dispValid_o); end
      drive(1'b0, 1'b0, 8'h00, 1);
   endtask

   initial begin
      reset_n = 1'b0;
      cnt0 = 0;
      q1.flush_i = 1'b0; q0.flush_i = 1'b0;
      q1.wrValid_i = 1'b0; q0.wrValid_i = 1'b0;
      q1.wrVector_i = '0; q0.wrVector_i = '0;
      q1.wrPacket_i = '0; q0.wrPacket_i = '0;
      q1.consume_i = '0; q0.consume_i = '0;
      test_reset();
      test_sparse();
      test_partial();
      test_full_boundary();
      test_wrap();
      test_flush();
      test_clamp();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
